// File: rtl/dll_seq_pkg.sv
// Shared definitions for the DLL lock sequencer: widths and FSM state encodings.
package dll_seq_pkg;

    localparam int TRIM_W = 26;
    localparam int DIV_W  = 5;
    localparam int POP_W  = 5;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DCO    = 3'd5
    } state_t;

    // States in which the DLL output clock is considered trustworthy for the core.
    function automatic logic clk_trusted(input state_t s);
        return (s == ST_LOCKED) || (s == ST_HOLD) || (s == ST_DCO);
    endfunction

endpackage

// File: rtl/trim_popcount_diff.sv
// Number of differing bits between two trim words (XOR followed by popcount).
module trim_popcount_diff
    import dll_seq_pkg::*;
(
    input  logic [TRIM_W-1:0] trim_a,
    input  logic [TRIM_W-1:0] trim_b,
    output logic [POP_W-1:0]  diff_bits
);

    logic [TRIM_W-1:0] diff_vec;

    genvar gi;
    generate
        for (gi = 0; gi < TRIM_W; gi++) begin : g_xor
            assign diff_vec[gi] = trim_a[gi] ^ trim_b[gi];
        end
    endgenerate

    // Count the set bits of the difference vector.
    always_comb begin
        diff_bits = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            diff_bits = diff_bits + POP_W'(diff_vec[i]);
        end
    end

endmodule

// File: rtl/dll_lock_sequencer.sv
// Supervisory sequencer for the DLL: startup, settling, lock detection,
// loss-of-lock detection, timeout fallback to DCO mode and core-clock gating.
module dll_lock_sequencer
    import dll_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 256,
    parameter int WINDOW_CYCLES = 64,
    parameter int LOCK_WINDOWS  = 4,
    parameter int MAX_WINDOWS   = 64,
    parameter int TOL_LOCK      = 1,
    parameter int TOL_UNLOCK    = 3
)
(
    input  logic              clock,
    input  logic              resetb,
    input  logic              req_enable,
    input  logic              req_dco,
    input  logic [TRIM_W-1:0] sw_trim,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [TRIM_W-1:0] trim_in,
    input  logic              clear_flags,
    output logic              dll_enable,
    output logic              dll_dco,
    output logic [DIV_W-1:0]  dll_div,
    output logic [TRIM_W-1:0] dll_ext_trim,
    output logic              locked,
    output logic              lock_fail,
    output logic              lost_lock,
    output logic              clk_sel,
    output logic [2:0]        state
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int WCW = $clog2(WINDOW_CYCLES + 1);
    localparam int LWW = $clog2(LOCK_WINDOWS + 1);
    localparam int MWW = $clog2(MAX_WINDOWS + 1);

    localparam logic [SCW-1:0]   SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
    localparam logic [WCW-1:0]   WINDOW_LAST  = WCW'(WINDOW_CYCLES - 1);
    localparam logic [LWW-1:0]   LOCK_TARGET  = LWW'(LOCK_WINDOWS);
    localparam logic [MWW-1:0]   MAX_TARGET   = MWW'(MAX_WINDOWS);
    localparam logic [POP_W-1:0] TOL_LOCK_C   = POP_W'(TOL_LOCK);
    localparam logic [POP_W-1:0] TOL_UNLOCK_C = POP_W'(TOL_UNLOCK);

    state_t state_reg, state_next;

    logic [TRIM_W-1:0] trim_s1_reg, trim_s2_reg, trim_s3_reg;
    logic [TRIM_W-1:0] trim_f_reg;
    logic [TRIM_W-1:0] snap_reg;

    logic [SCW-1:0] settle_cnt_reg;
    logic [WCW-1:0] win_cyc_reg;
    logic [LWW-1:0] stable_cnt_reg, stable_cnt_next;
    logic [MWW-1:0] win_cnt_reg, win_cnt_next;

    logic              dll_enable_reg, dll_dco_reg, locked_reg, clk_sel_reg;
    logic              lock_fail_reg, lost_lock_reg;
    logic [DIV_W-1:0]  dll_div_reg;
    logic [TRIM_W-1:0] dll_ext_trim_reg;

    logic [POP_W-1:0] diff_bits;
    logic             win_end, settle_done, set_fail, set_lost;

    assign win_end     = (win_cyc_reg == WINDOW_LAST);
    assign settle_done = (settle_cnt_reg == SETTLE_LAST);

    // One comparator serves both the stability and the loss-of-lock tolerance.
    trim_popcount_diff u_diff (
        .trim_a    (trim_f_reg),
        .trim_b    (snap_reg),
        .diff_bits (diff_bits)
    );

    // Window bookkeeping for TRACK; both counters saturate.
    always_comb begin
        stable_cnt_next = '0;
        if (diff_bits <= TOL_LOCK_C) begin
            stable_cnt_next = (stable_cnt_reg == LOCK_TARGET) ? stable_cnt_reg
                                                              : stable_cnt_reg + LWW'(1);
        end
        win_cnt_next = (win_cnt_reg == MAX_TARGET) ? win_cnt_reg : win_cnt_reg + MWW'(1);
    end

    // Synchronize the asynchronous trim word; accept it only after two equal samples
    // so a multi-bit word caught mid-transition is never used.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            trim_s1_reg <= '0;
            trim_s2_reg <= '0;
            trim_s3_reg <= '0;
            trim_f_reg  <= '0;
        end else begin
            trim_s1_reg <= trim_in;
            trim_s2_reg <= trim_s1_reg;
            trim_s3_reg <= trim_s2_reg;
            if (trim_s2_reg == trim_s3_reg) begin
                trim_f_reg <= trim_s2_reg;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg <= ST_OFF;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: disable and DCO requests override the per-state rules.
    always_comb begin
        state_next = state_reg;
        set_fail   = 1'b0;
        set_lost   = 1'b0;
        if (!req_enable) begin
            state_next = ST_OFF;
        end else if (req_dco && (state_reg != ST_DCO)) begin
            state_next = ST_DCO;
        end else begin
            case (state_reg)
                ST_OFF:    state_next = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_next = ST_TRACK;
                ST_TRACK: begin
                    if (win_end) begin
                        // Lock takes precedence over timeout at the same window end.
                        if (stable_cnt_next >= LOCK_TARGET) begin
                            state_next = ST_LOCKED;
                        end else if (win_cnt_next >= MAX_TARGET) begin
                            state_next = ST_HOLD;
                            set_fail   = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (win_end && (diff_bits > TOL_UNLOCK_C)) begin
                        state_next = ST_TRACK;
                        set_lost   = 1'b1;
                    end
                end
                ST_HOLD:   state_next = ST_HOLD;
                ST_DCO:    if (!req_dco) state_next = ST_SETTLE;
                default:   state_next = ST_OFF;
            endcase
        end
    end

    // Settling, window-cycle and window-statistics counters.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            settle_cnt_reg <= '0;
            win_cyc_reg    <= '0;
            stable_cnt_reg <= '0;
            win_cnt_reg    <= '0;
        end else begin
            if (state_reg != ST_SETTLE) begin
                settle_cnt_reg <= '0;
            end else if (!settle_done) begin
                settle_cnt_reg <= settle_cnt_reg + SCW'(1);
            end

            if ((state_reg == ST_TRACK) || (state_reg == ST_LOCKED)) begin
                win_cyc_reg <= win_end ? '0 : win_cyc_reg + WCW'(1);
            end else begin
                win_cyc_reg <= '0;
            end

            // Statistics only matter in TRACK; held at zero elsewhere so every
            // entry into TRACK (from SETTLE or after a loss of lock) starts fresh.
            if (state_reg == ST_TRACK) begin
                if (win_end) begin
                    stable_cnt_reg <= stable_cnt_next;
                    win_cnt_reg    <= win_cnt_next;
                end
            end else begin
                stable_cnt_reg <= '0;
                win_cnt_reg    <= '0;
            end
        end
    end

    // Trim snapshot: taken when tracking begins and refreshed at every window end.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            snap_reg <= '0;
        end else if ((state_reg == ST_SETTLE) && (state_next == ST_TRACK)) begin
            snap_reg <= trim_f_reg;
        end else if (((state_reg == ST_TRACK) || (state_reg == ST_LOCKED)) && win_end) begin
            snap_reg <= trim_f_reg;
        end
    end

    // Registered DLL controls and status, derived from the state being entered.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            dll_enable_reg   <= 1'b0;
            dll_dco_reg      <= 1'b0;
            locked_reg       <= 1'b0;
            clk_sel_reg      <= 1'b0;
            dll_div_reg      <= '0;
            dll_ext_trim_reg <= '0;
        end else begin
            dll_enable_reg <= (state_next != ST_OFF);
            dll_dco_reg    <= (state_next == ST_HOLD) || (state_next == ST_DCO);
            locked_reg     <= (state_next == ST_LOCKED);
            // Rises one cycle after entering a trusted state, drops on the exit edge.
            clk_sel_reg    <= clk_trusted(state_reg) && clk_trusted(state_next);
            if ((state_reg == ST_OFF) && (state_next != ST_OFF)) begin
                dll_div_reg <= div_in;
            end
            if (state_next == ST_DCO) begin
                dll_ext_trim_reg <= sw_trim;
            end else if ((state_reg == ST_TRACK) && (state_next == ST_HOLD)) begin
                dll_ext_trim_reg <= trim_f_reg;
            end
        end
    end

    // Sticky fault flags: a set event beats a simultaneous clear.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            lock_fail_reg <= 1'b0;
            lost_lock_reg <= 1'b0;
        end else begin
            if (set_fail) begin
                lock_fail_reg <= 1'b1;
            end else if (clear_flags) begin
                lock_fail_reg <= 1'b0;
            end
            if (set_lost) begin
                lost_lock_reg <= 1'b1;
            end else if (clear_flags) begin
                lost_lock_reg <= 1'b0;
            end
        end
    end

    assign dll_enable   = dll_enable_reg;
    assign dll_dco      = dll_dco_reg;
    assign dll_div      = dll_div_reg;
    assign dll_ext_trim = dll_ext_trim_reg;
    assign locked       = locked_reg;
    assign lock_fail    = lock_fail_reg;
    assign lost_lock    = lost_lock_reg;
    assign clk_sel      = clk_sel_reg;
    assign state        = state_reg;

endmodule
